// File: rtl/l4_result_tx.sv
`timescale 1ns/1ps
// l4_result_tx
// Streams the 64 signed layer-4 results out of a UART as one 192-byte frame.
// Each 18-bit result is sign-extended to 24 bits and sent MSB byte first.
// Every byte is 8N1 with the data LSB first, and bytes follow each other
// with no idle gap.
//
// Parameters:
//   BAUD_DIV  clock cycles per UART bit (2..65535)
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   strt     results-valid level; a rising edge launches one frame
//   din      64 x 18-bit signed results, held stable by the producer until tx_done
//   tx       UART serial output, idle high
//   busy     high from frame start through the DONE cycle
//   tx_done  one-cycle pulse after the final stop bit
module l4_result_tx #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt,
  input  logic [17:0] din [63:0],
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_strt;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [1:0]  r_byte;
  logic [5:0]  r_word;
  logic [23:0] r_hold;
  logic [7:0]  r_shift;
  logic        r_tx;

  logic        w_edge;
  logic        w_baud_end;
  logic        w_last_byte;
  logic [23:0] w_din_sx;
  logic [7:0]  w_load_byte;
  logic        w_tx_next;

  assign w_edge      = strt & ~r_strt;
  assign w_baud_end  = (r_baud == BAUD_LAST);
  // Byte 191 is word 63, byte 2; the frame ends there instead of wrapping.
  assign w_last_byte = (r_word == 6'd63) && (r_byte == 2'd2);
  assign w_din_sx    = {{6{din[r_word][17]}}, din[r_word]};

  // Byte 0 of a word comes straight from din; bytes 1 and 2 come from the
  // copy captured when byte 0 was loaded, so din is sampled once per word.
  always_comb begin
    w_load_byte = r_hold[7:0];
    case (r_byte)
      2'd0:    w_load_byte = w_din_sx[23:16];
      2'd1:    w_load_byte = r_hold[15:8];
      default: w_load_byte = r_hold[7:0];
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (w_edge) w_state_next = START;
      START: if (w_baud_end) w_state_next = DATA;
      DATA:  if (w_baud_end && (r_bit == 3'd7)) w_state_next = STOP;
      STOP:  if (w_baud_end) w_state_next = w_last_byte ? DONE : START;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // tx is registered; its next value anticipates what the shift register
  // will hold after this edge so the line changes exactly at bit boundaries.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START: w_tx_next = 1'b0;
      DATA: begin
        if (r_state == START)
          w_tx_next = w_load_byte[0];
        else if (w_baud_end)
          w_tx_next = r_shift[1];
        else
          w_tx_next = r_shift[0];
      end
      default: w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_strt  <= 1'b0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_word  <= '0;
      r_hold  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_strt  <= strt;
      r_state <= w_state_next;
      r_tx    <= w_tx_next;

      if ((r_state == IDLE) || (r_state == DONE) || w_baud_end)
        r_baud <= '0;
      else
        r_baud <= r_baud + 16'd1;

      if (r_state == IDLE) begin
        r_bit  <= '0;
        r_byte <= '0;
        r_word <= '0;
      end

      if ((r_state == START) && w_baud_end) begin
        if (r_byte == 2'd0)
          r_hold <= w_din_sx;
        r_shift <= w_load_byte;
      end

      if ((r_state == DATA) && w_baud_end) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 3'd1;
      end

      if ((r_state == STOP) && w_baud_end && !w_last_byte) begin
        if (r_byte == 2'd2) begin
          r_byte <= 2'd0;
          r_word <= r_word + 6'd1;
        end else begin
          r_byte <= r_byte + 2'd1;
        end
      end
    end
  end

  assign tx      = r_tx;
  assign busy    = (r_state != IDLE);
  assign tx_done = (r_state == DONE);

endmodule
